// File: rtl/aes_pkg.sv
// Shared constants and GF(2^8) helpers for the AES-128 encryption core.
// Optional feature macro: AES_ENC_KEY_OUT_EN (exposes the final round key).
package aes_pkg;

   localparam int AES_ROUNDS = 10;
   localparam int FSM_W      = 4;

   // Round-counter encodings: 0 idle, 1..10 round pending, 11 result ready
   localparam logic [FSM_W-1:0] FSM_IDLE  = 4'd0;
   localparam logic [FSM_W-1:0] FSM_FIRST = 4'd1;
   localparam logic [FSM_W-1:0] FSM_LAST  = 4'(AES_ROUNDS);
   localparam logic [FSM_W-1:0] FSM_DONE  = 4'd11;

   localparam logic [7:0] RCON_INIT = 8'h01;
   localparam logic [7:0] RCON_LAST = 8'h36;
   localparam logic [7:0] GF_POLY   = 8'h1b;

   // Multiply by x in GF(2^8), reducing with the AES polynomial
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
   endfunction

   // General GF(2^8) product by shift-and-add
   function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] prod;
      logic [7:0] addend;
      prod   = 8'h00;
      addend = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) prod = prod ^ addend;
         addend = xtime(addend);
      end
      return prod;
   endfunction

   // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0
   function automatic logic [7:0] gfInv(input logic [7:0] a);
      logic [7:0] sq;
      logic [7:0] acc;
      sq  = a;
      acc = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gfMul(sq, sq);
         acc = gfMul(acc, sq);
      end
      return acc;
   endfunction

endpackage

// File: rtl/aes_key_shedualing.sv
// Forward AES-128 key expansion step: produces the next round key and next rcon.
module aes_key_shedualing
   import aes_pkg::*;
(
   input  logic [127:0] keyIn,
   input  logic [7:0]   rconIn,
   output logic [127:0] keyOut,
   output logic [7:0]   rconOut
);

   logic [31:0] rotWord;
   logic [31:0] subWord;
   logic [31:0] temp;
   logic [31:0] w0, w1, w2, w3;

   assign rotWord = {keyIn[23:0], keyIn[31:24]};

   genvar gb;
   for (gb = 0; gb < 4; gb++) begin : g_subword
      aes_sbox u_sbox (
         .byteIn (rotWord[31-8*gb -: 8]),
         .byteOut(subWord[31-8*gb -: 8])
      );
   end

   // Each new word chains off the previous new word; only word 0 sees the rcon/S-box term
   always_comb begin
      temp    = subWord ^ {rconIn, 24'h000000};
      w0      = keyIn[127:96] ^ temp;
      w1      = keyIn[95:64]  ^ w0;
      w2      = keyIn[63:32]  ^ w1;
      w3      = keyIn[31:0]   ^ w2;
      keyOut  = {w0, w1, w2, w3};
      rconOut = xtime(rconIn);
   end

endmodule

// File: rtl/aes_mixw.sv
// MixColumns applied to one 32-bit column; top byte is row 0.
module aes_mixw
   import aes_pkg::*;
(
   input  logic [31:0] colIn,
   output logic [31:0] colOut
);

   logic [7:0] a0, a1, a2, a3;

   // Circulant matrix rows (2 3 1 1), with 3*x formed as xtime(x) ^ x
   always_comb begin
      a0 = colIn[31:24];
      a1 = colIn[23:16];
      a2 = colIn[15:8];
      a3 = colIn[7:0];
      colOut[31:24] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
      colOut[23:16] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
      colOut[15:8]  = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
      colOut[7:0]   = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
   end

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box: GF(2^8) inverse followed by the affine transform.
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] byteIn,
   output logic [7:0] byteOut
);

   logic [7:0] inverse;

   // The affine step XORs the inverse with four left rotations of itself plus 0x63
   always_comb begin
      inverse = gfInv(byteIn);
      byteOut = inverse
              ^ {inverse[6:0], inverse[7]}
              ^ {inverse[5:0], inverse[7:6]}
              ^ {inverse[4:0], inverse[7:5]}
              ^ {inverse[3:0], inverse[7:4]}
              ^ 8'h63;
   end

endmodule

// File: rtl/aes_enc_top.sv
// Iterative AES-128 encryption core, one round per clock, 11-cycle block period.
// Optional feature macro: AES_ENC_KEY_OUT_EN adds key_last_o (final round key).
module aes_enc_top
   import aes_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         data_v_i,
   input  logic [127:0] data_i,
   input  logic [127:0] key_i,
   output logic [127:0] res_o,
   output logic         res_v_o,
   output logic         busy_o
`ifdef AES_ENC_KEY_OUT_EN
   ,
   output logic [127:0] key_last_o
`endif
);

   logic [FSM_W-1:0] fsmQ;
   logic [127:0]     dataQ;
   logic [127:0]     keyQ;
   logic [7:0]       rconQ;

   logic [127:0] subBytes;
   logic [127:0] shiftRows;
   logic [127:0] mixCols;
   logic [127:0] schedKeyIn;
   logic [7:0]   schedRconIn;
   logic [127:0] schedKeyOut;
   logic [7:0]   schedRconOut;

   genvar gb, gc, gr;

   for (gb = 0; gb < 16; gb++) begin : g_subbytes
      aes_sbox u_sbox (
         .byteIn (dataQ[127-8*gb -: 8]),
         .byteOut(subBytes[127-8*gb -: 8])
      );
   end

   // Row r of column c takes the byte from column (c + r) mod 4
   for (gc = 0; gc < 4; gc++) begin : g_shift_col
      for (gr = 0; gr < 4; gr++) begin : g_shift_row
         assign shiftRows[127-32*gc-8*gr -: 8] = subBytes[127-32*((gc+gr)%4)-8*gr -: 8];
      end
   end

   for (gc = 0; gc < 4; gc++) begin : g_mix
      aes_mixw u_mixw (
         .colIn (shiftRows[127-32*gc -: 32]),
         .colOut(mixCols[127-32*gc -: 32])
      );
   end

   // A single scheduler serves both the start edge (fresh key, first rcon) and later rounds
   always_comb begin
      schedKeyIn  = data_v_i ? key_i     : keyQ;
      schedRconIn = data_v_i ? RCON_INIT : rconQ;
   end

   aes_key_shedualing u_key_sched (
      .keyIn  (schedKeyIn),
      .rconIn (schedRconIn),
      .keyOut (schedKeyOut),
      .rconOut(schedRconOut)
   );

   // Round sequencer: a start strobe always wins, so it both aborts a running block
   // and chains a new block straight out of DONE; the key stops advancing after
   // round 9 so that keyQ ends on the round-10 key
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsmQ  <= FSM_IDLE;
         dataQ <= '0;
         keyQ  <= '0;
         rconQ <= RCON_INIT;
      end else if (data_v_i) begin
         fsmQ  <= FSM_FIRST;
         dataQ <= data_i ^ key_i;
         keyQ  <= schedKeyOut;
         rconQ <= schedRconOut;
      end else if (fsmQ >= FSM_FIRST && fsmQ < FSM_LAST) begin
         fsmQ  <= fsmQ + 4'd1;
         dataQ <= mixCols ^ keyQ;
         keyQ  <= schedKeyOut;
         rconQ <= schedRconOut;
      end else if (fsmQ == FSM_LAST) begin
         fsmQ  <= FSM_DONE;
         dataQ <= shiftRows ^ keyQ;
      end else if (fsmQ != FSM_IDLE) begin
         fsmQ  <= FSM_IDLE;
      end
   end

   // Status outputs decode directly from the round counter
   always_comb begin
      res_o   = dataQ;
      res_v_o = (fsmQ == FSM_DONE);
      busy_o  = (fsmQ >= FSM_FIRST) && (fsmQ <= FSM_LAST);
   end

`ifdef AES_ENC_KEY_OUT_EN
   assign key_last_o = keyQ;
`endif

endmodule

// File: tb/tb_aes_enc_top.sv
// Directed, table-driven bench for aes_enc_top using published AES-128 vectors.
module tb_aes_enc_top;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
      logic [127:0] ct;
      logic [127:0] keyLast;
   } Vec;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         dataValid = 1'b0;
   logic [127:0] dataIn = '0;
   logic [127:0] keyIn = '0;
   logic [127:0] resOut;
   logic         resValid;
   logic         busy;
`ifdef AES_ENC_KEY_OUT_EN
   logic [127:0] keyLast;
`endif

   int compared = 0;
   int mismatched = 0;
   Vec vecs[4];

   aes_enc_top dut (
      .clk     (clock),
      .rst     (reset),
      .data_v_i(dataValid),
      .data_i  (dataIn),
      .key_i   (keyIn),
      .res_o   (resOut),
      .res_v_o (resValid),
      .busy_o  (busy)
`ifdef AES_ENC_KEY_OUT_EN
      ,
      .key_last_o(keyLast)
`endif
   );

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   // One comparison: counts it and reports any difference
   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
      end
   endtask

   // Presents a start strobe for exactly one edge; returns at the negedge after that edge
   task automatic applyStimulus(input logic [127:0] key, input logic [127:0] pt);
      @(negedge clock);
      dataValid = 1'b1;
      dataIn    = pt;
      keyIn     = key;
      @(posedge clock);
      @(negedge clock);
      dataValid = 1'b0;
   endtask

   // Counts edges until res_v_o is seen, bounded to 20; -1 means it never came
   task automatic waitResult(output int edges);
      bit seen;
      seen  = 1'b0;
      edges = -1;
      for (int i = 1; i <= 20 && !seen; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (resValid) begin
            seen  = 1'b1;
            edges = i;
         end
      end
   endtask

   // Advances n cycles and returns how many of them showed res_v_o high
   task automatic countPulses(input int n, output int pulses);
      pulses = 0;
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         @(negedge clock);
         if (resValid) pulses++;
      end
   endtask

   initial begin
      int edges;
      int pulses;

      vecs[0] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h13111d7fe3944a17f307a78b4d2b30c5};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734,
                  128'h3925841d02dc09fbdc118597196a0b32, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[2] = '{128'h00000000000000000000000000000000, 128'h00000000000000000000000000000000,
                  128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};
      vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a,
                  128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

      // Reset state
      repeat (2) @(negedge clock);
      checkOutput("reset res_o", resOut, 128'h0);
      checkOutput("reset res_v_o", 128'(resValid), 128'h0);
      checkOutput("reset busy_o", 128'(busy), 128'h0);
      reset = 1'b0;
      @(negedge clock);

      // Table-driven single blocks
      for (int v = 0; v < 4; v++) begin
         applyStimulus(vecs[v].key, vecs[v].pt);
         checkOutput($sformatf("vec%0d busy after start", v), 128'(busy), 128'h1);
         waitResult(edges);
         checkOutput($sformatf("vec%0d latency", v), 128'(edges), 128'd10);
         checkOutput($sformatf("vec%0d ciphertext", v), resOut, vecs[v].ct);
         checkOutput($sformatf("vec%0d busy in done", v), 128'(busy), 128'h0);
`ifdef AES_ENC_KEY_OUT_EN
         checkOutput($sformatf("vec%0d key_last_o", v), keyLast, vecs[v].keyLast);
`endif
         @(posedge clock);
         @(negedge clock);
         checkOutput($sformatf("vec%0d pulse width", v), 128'(resValid), 128'h0);
         checkOutput($sformatf("vec%0d idle hold", v), resOut, vecs[v].ct);
      end

      // Back-to-back: second start lands in the DONE cycle of the first
      applyStimulus(vecs[0].key, vecs[0].pt);
      waitResult(edges);
      checkOutput("b2b first ciphertext", resOut, vecs[0].ct);
      dataValid = 1'b1;
      dataIn    = vecs[1].pt;
      keyIn     = vecs[1].key;
      @(posedge clock);
      @(negedge clock);
      dataValid = 1'b0;
      checkOutput("b2b restart busy", 128'(busy), 128'h1);
      checkOutput("b2b res_v_o dropped", 128'(resValid), 128'h0);
      waitResult(edges);
      checkOutput("b2b pulse spacing", 128'(edges + 1), 128'd11);
      checkOutput("b2b second ciphertext", resOut, vecs[1].ct);
      countPulses(3, pulses);

      // Abort: restart with a new block while round 5 is pending
      applyStimulus(vecs[0].key, vecs[0].pt);
      countPulses(4, pulses);
      checkOutput("abort no early pulse", 128'(pulses), 128'd0);
      dataValid = 1'b1;
      dataIn    = vecs[1].pt;
      keyIn     = vecs[1].key;
      @(posedge clock);
      @(negedge clock);
      dataValid = 1'b0;
      waitResult(edges);
      checkOutput("abort latency", 128'(edges), 128'd10);
      checkOutput("abort ciphertext", resOut, vecs[1].ct);
      countPulses(12, pulses);
      checkOutput("abort single pulse", 128'(pulses), 128'd0);

      // Reset asserted while round 7 is pending
      applyStimulus(vecs[0].key, vecs[0].pt);
      countPulses(6, pulses);
      reset = 1'b1;
      #1;
      checkOutput("midreset res_o", resOut, 128'h0);
      checkOutput("midreset res_v_o", 128'(resValid), 128'h0);
      checkOutput("midreset busy_o", 128'(busy), 128'h0);
      @(negedge clock);
      reset = 1'b0;
      countPulses(15, pulses);
      checkOutput("midreset no pulse after release", 128'(pulses), 128'd0);
      applyStimulus(vecs[1].key, vecs[1].pt);
      waitResult(edges);
      checkOutput("post-reset latency", 128'(edges), 128'd10);
      checkOutput("post-reset ciphertext", resOut, vecs[1].ct);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/aes_enc_top.md
AES_ENC_TOP -- requirements
Module: aes_enc_top

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clock and reset are listed first below.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 data_v_i  input  1  start strobe; data_i and key_i are sampled on the same edge.
REQ-005 data_i  input  128  plaintext block; [127:120] is state byte s(0,0); column c occupies bits [127-32c:96-32c]; top byte of each column is row 0.
REQ-006 key_i  input  128  AES-128 cipher key, same byte order as data_i.
REQ-007 res_o  output  128  ciphertext, same byte order as data_i.
REQ-008 res_v_o  output  1  res_o valid, high for exactly one cycle.
REQ-009 busy_o  output  1  high while rounds 1..10 are in progress.

Function
REQ-010 The block SHALL hold a 4-bit round counter fsm_q: 0 = IDLE, 1..10 = round n pending, 11 = DONE.
REQ-011 On an edge with data_v_i=1, in any state: data_q <= data_i ^ key_i; key_q <= round-1 key expanded from key_i with rcon 8'h01; fsm_q <= 1.
REQ-012 On an edge with data_v_i=0 and fsm_q in 1..9: data_q <= MixColumns(ShiftRows(SubBytes(data_q))) ^ key_q; key_q and rcon advance one step; fsm_q increments.
REQ-013 On an edge with data_v_i=0 and fsm_q=10: data_q <= ShiftRows(SubBytes(data_q)) ^ key_q, with MixColumns bypassed; fsm_q <= 11.
REQ-014 In DONE (fsm_q=11), the next edge with data_v_i=0 SHALL return fsm_q to 0, and data_q and key_q SHALL hold.
REQ-015 In IDLE with data_v_i=0, all registers SHALL hold.
REQ-016 res_v_o = (fsm_q==11); busy_o = (fsm_q in 1..10); res_o = data_q continuously, meaningful only while res_v_o=1.
REQ-017 Latency SHALL be fixed: if data_v_i is sampled at edge E0, res_v_o is high between E10 and E11; throughput is one block per 11 cycles.
REQ-018 If data_v_i=1 while busy, the block SHALL abort the current block and restart with no res_v_o for the aborted block.
REQ-019 If data_v_i=1 in DONE, res_v_o SHALL still be high for that cycle, and the new block starts per REQ-011 (back-to-back, 11-cycle period).
REQ-020 rcon SHALL advance as a GF(2^8) doubling (xtime, poly 8'h1b): 01,02,04,08,10,20,40,80,1b,36.

Reset
REQ-021 While rst=1 (asynchronous assertion), fsm_q=0, data_q=0, key_q=0 and rcon=8'h01; res_v_o=0, busy_o=0, res_o=0.
REQ-022 Reset asserted mid-operation SHALL discard the block; no res_v_o is produced after release until a new data_v_i.

Configuration
REQ-023 Macro AES_ENC_KEY_OUT_EN defined: the block SHALL add output key_last_o (128 bits) = key_q, which holds the round-10 key while res_v_o=1; this is the key_i format the decryption core expects.
REQ-024 Macro AES_ENC_KEY_OUT_EN undefined: the block SHALL omit key_last_o; all other behaviour is identical.

Structure
REQ-025 Package aes_pkg SHALL hold: AES_ROUNDS=10, FSM width 4, FSM_DONE=4'd11, RCON_INIT=8'h01, RCON_LAST=8'h36, GF polynomial 8'h1b.
REQ-026 Forward key expansion (RotWord/SubWord/rcon XOR, next rcon) SHALL be the sub-module aes_key_shedualing, the forward counterpart of the existing inverse scheduler; existing aes_sbox/aes_mixw cells are reused.

Verification
REQ-027 key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> res_o 69c4e0d86a7b0430d8cdb78070b4c55a, res_v_o high exactly 10 edges after start.
REQ-028 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32; with AES_ENC_KEY_OUT_EN, key_last_o=d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-029 Back-to-back: second data_v_i in the DONE cycle -> two one-cycle res_v_o pulses 11 cycles apart, both results correct.
REQ-030 Abort: restart with the REQ-028 vector at fsm_q=5 of the REQ-027 vector -> a single res_v_o carrying 3925841d..., 10 edges after restart.
REQ-031 rst pulse at fsm_q=7 -> outputs 0 immediately, no res_v_o afterwards; the next start produces a correct result.
REQ-032 Loopback: feed res_o and key_last_o to the decryption core -> original plaintext recovered.
